// File: rtl/signal_edge_driver.sv
// Turns single-cycle rise/fall request pulses into a registered level with
// enforced minimum high/low times, one queued edge, and a drop indicator.
module signal_edge_driver #(
   parameter int MIN_HIGH = 4,
   parameter int MIN_LOW  = 4,
   parameter int CNT_W    = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        rise_req,
   input  logic        fall_req,
   output logic        signal_out,
   output logic        busy,
   output logic        dropped,
   output logic [15:0] edge_count
);

   typedef enum logic [1:0] {
      LOW_IDLE  = 2'b00,
      LOW_HOLD  = 2'b01,
      HIGH_IDLE = 2'b10,
      HIGH_HOLD = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] HIGH_RELOAD = CNT_W'(MIN_HIGH - 1);
   localparam logic [CNT_W-1:0] LOW_RELOAD  = CNT_W'(MIN_LOW - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pending_q, pending_d;
   logic             out_q, out_d;
   logic             dropped_q, dropped_d;
   logic [15:0]      edge_q, edge_d;

   logic opp_req, same_req, eff_pending, fire;

   // When both requests arrive together only the opposite one is honoured.
   assign opp_req  = out_q ? fall_req : rise_req;
   assign same_req = (out_q ? rise_req : fall_req) & ~opp_req;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pending_d   = pending_q;
      out_d       = out_q;
      dropped_d   = 1'b0;
      edge_d      = edge_q;
      fire        = 1'b0;
      eff_pending = 1'b0;

      case (state_q)
         LOW_IDLE, HIGH_IDLE: begin
            if (opp_req) begin
               fire = 1'b1;
            end else if (same_req) begin
               dropped_d = 1'b1;
            end
         end
         default: begin
            // A same-level request cancels a queued edge rather than being dropped.
            eff_pending = (pending_q & ~same_req) | opp_req;
            dropped_d   = (opp_req & pending_q) | (same_req & ~pending_q);
            if (cnt_q == '0) begin
               if (eff_pending) begin
                  fire = 1'b1;
               end else begin
                  state_d   = out_q ? HIGH_IDLE : LOW_IDLE;
                  pending_d = 1'b0;
               end
            end else begin
               cnt_d     = cnt_q - 1'b1;
               pending_d = eff_pending;
            end
         end
      endcase

      if (fire) begin
         out_d     = ~out_q;
         cnt_d     = out_q ? LOW_RELOAD : HIGH_RELOAD;
         state_d   = out_q ? LOW_HOLD : HIGH_HOLD;
         pending_d = 1'b0;
         edge_d    = edge_q + 16'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= LOW_IDLE;
         cnt_q     <= '0;
         pending_q <= 1'b0;
         out_q     <= 1'b0;
         dropped_q <= 1'b0;
         edge_q    <= 16'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         out_q     <= out_d;
         dropped_q <= dropped_d;
         edge_q    <= edge_d;
      end
   end

   assign signal_out = out_q;
   assign busy       = (state_q == LOW_HOLD) | (state_q == HIGH_HOLD) | pending_q;
   assign dropped    = dropped_q;
   assign edge_count = edge_q;

endmodule

// File: tb/tb_signal_edge_driver.sv
// Scenario bench for signal_edge_driver: per-cycle expected outputs are queued
// as stimulus is driven and compared after the following clock edge.
module tb_signal_edge_driver;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        rise_req = 1'b0;
   logic        fall_req = 1'b0;
   logic        out_a, busy_a, drop_a;
   logic [15:0] cnt_a;
   logic        out_b, busy_b, drop_b;
   logic [15:0] cnt_b;

   int total = 0;
   int bad   = 0;
   logic [18:0] exp_q[$];

   signal_edge_driver #(.MIN_HIGH(4), .MIN_LOW(3), .CNT_W(8)) dut (
      .clock(clock), .reset(reset), .rise_req(rise_req), .fall_req(fall_req),
      .signal_out(out_a), .busy(busy_a), .dropped(drop_a), .edge_count(cnt_a)
   );

   signal_edge_driver #(.MIN_HIGH(1), .MIN_LOW(1), .CNT_W(8)) dut_fast (
      .clock(clock), .reset(reset), .rise_req(rise_req), .fall_req(fall_req),
      .signal_out(out_b), .busy(busy_b), .dropped(drop_b), .edge_count(cnt_b)
   );

   always #5 clock = ~clock;

   function automatic logic [18:0] pack(input logic o, input logic b, input logic d,
                                        input int n);
      return {o, b, d, 16'(n)};
   endfunction

   task automatic do_reset();
      reset = 1'b1; rise_req = 1'b0; fall_req = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   // Outputs asserted as zero while reset is held, even with a request present.
   task automatic test_reset();
      logic [18:0] e, g;
      reset = 1'b1; rise_req = 1'b1; fall_req = 1'b0;
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(pack(0, 0, 0, 0));
         @(posedge clock); #1;
         g = {out_a, busy_a, drop_a, cnt_a};
         e = exp_q.pop_front();
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL reset k=%0d got out/busy/drop/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d",
                     k, g[18], g[17], g[16], g[15:0], e[18], e[17], e[16], e[15:0]);
         end
      end
      rise_req = 1'b0;
      do_reset();
   endtask

   // Single rise at cycle 5: high from 6, hold 6..9, idle from 10.
   task automatic test_single_rise();
      logic [18:0] e, g;
      do_reset();
      for (int k = 0; k < 14; k++) begin
         int c = k + 1;
         rise_req = (k == 5); fall_req = 1'b0;
         exp_q.push_back(pack(c >= 6, c >= 6 && c <= 9, 0, (c >= 6) ? 1 : 0));
         @(posedge clock); #1;
         g = {out_a, busy_a, drop_a, cnt_a};
         e = exp_q.pop_front();
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL single_rise c=%0d got out/busy/drop/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d",
                     c, g[18], g[17], g[16], g[15:0], e[18], e[17], e[16], e[15:0]);
         end
      end
   endtask

   // Rise at 5, fall queued at 7: high 6..9, low from 10, busy through 12.
   // With second_fall, another fall at 8 is dropped (pulse at 9).
   task automatic test_queued_fall(input logic second_fall);
      logic [18:0] e, g;
      do_reset();
      for (int k = 0; k < 15; k++) begin
         int c = k + 1;
         rise_req = (k == 5);
         fall_req = (k == 7) || (second_fall && k == 8);
         exp_q.push_back(pack(c >= 6 && c <= 9, c >= 6 && c <= 12,
                              second_fall && c == 9,
                              (c >= 10) ? 2 : (c >= 6) ? 1 : 0));
         @(posedge clock); #1;
         g = {out_a, busy_a, drop_a, cnt_a};
         e = exp_q.pop_front();
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL queued_fall(%0d) c=%0d got out/busy/drop/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d",
                     second_fall, c, g[18], g[17], g[16], g[15:0],
                     e[18], e[17], e[16], e[15:0]);
         end
      end
   endtask

   // Rise at 5, fall at 7 queued, rise at 8 cancels it: stays high, no drop.
   task automatic test_cancel();
      logic [18:0] e, g;
      do_reset();
      for (int k = 0; k < 15; k++) begin
         int c = k + 1;
         rise_req = (k == 5) || (k == 8);
         fall_req = (k == 7);
         exp_q.push_back(pack(c >= 6, c >= 6 && c <= 9, 0, (c >= 6) ? 1 : 0));
         @(posedge clock); #1;
         g = {out_a, busy_a, drop_a, cnt_a};
         e = exp_q.pop_front();
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL cancel c=%0d got out/busy/drop/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d",
                     c, g[18], g[17], g[16], g[15:0], e[18], e[17], e[16], e[15:0]);
         end
      end
   endtask

   // Both requests at 5 from low act as a rise; rise at 12 in HIGH_IDLE drops at 13.
   task automatic test_both_and_same();
      logic [18:0] e, g;
      do_reset();
      for (int k = 0; k < 16; k++) begin
         int c = k + 1;
         rise_req = (k == 5) || (k == 12);
         fall_req = (k == 5);
         exp_q.push_back(pack(c >= 6, c >= 6 && c <= 9, c == 13, (c >= 6) ? 1 : 0));
         @(posedge clock); #1;
         g = {out_a, busy_a, drop_a, cnt_a};
         e = exp_q.pop_front();
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL both_same c=%0d got out/busy/drop/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d",
                     c, g[18], g[17], g[16], g[15:0], e[18], e[17], e[16], e[15:0]);
         end
      end
   endtask

   // Reset at cycle 8 with a fall pending clears everything; nothing fires later.
   task automatic test_reset_mid_hold();
      logic [18:0] e, g;
      do_reset();
      for (int k = 0; k < 18; k++) begin
         int c = k + 1;
         rise_req = (k == 5); fall_req = (k == 7);
         reset    = (k == 8);
         if (c <= 8)
            exp_q.push_back(pack(c >= 6, c >= 6, 0, (c >= 6) ? 1 : 0));
         else
            exp_q.push_back(pack(0, 0, 0, 0));
         @(posedge clock); #1;
         g = {out_a, busy_a, drop_a, cnt_a};
         e = exp_q.pop_front();
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL reset_mid_hold c=%0d got out/busy/drop/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d",
                     c, g[18], g[17], g[16], g[15:0], e[18], e[17], e[16], e[15:0]);
         end
      end
      reset = 1'b0;
   endtask

   // MIN_HIGH=MIN_LOW=1: rise@2, fall@3, rise@4 give edges on consecutive cycles.
   task automatic test_back_to_back();
      logic [18:0] e, g;
      do_reset();
      for (int k = 0; k < 9; k++) begin
         int c = k + 1;
         rise_req = (k == 2) || (k == 4);
         fall_req = (k == 3);
         exp_q.push_back(pack(c == 3 || c >= 5, c >= 3 && c <= 5, 0,
                              (c >= 5) ? 3 : (c == 4) ? 2 : (c == 3) ? 1 : 0));
         @(posedge clock); #1;
         g = {out_b, busy_b, drop_b, cnt_b};
         e = exp_q.pop_front();
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL back_to_back c=%0d got out/busy/drop/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d",
                     c, g[18], g[17], g[16], g[15:0], e[18], e[17], e[16], e[15:0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_rise();
      test_queued_fall(1'b0);
      test_queued_fall(1'b1);
      test_cancel();
      test_both_and_same();
      test_reset_mid_hold();
      test_back_to_back();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain left=%0d want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
